// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR memory controller with memory handshake and keyboard/display MMIO
module lc3_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] busIn,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic        selMDR,
  input  logic        memWE,
  input  logic        memEN,
  input  logic        enaMDR,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] busOut,
  output logic        R,
  output logic        memReq,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWData,
  input  logic [15:0] memRData,
  input  logic        memAck,
  input  logic        kbValid,
  input  logic [7:0]  kbData,
  input  logic        dispReady,
  output logic        ddrValid,
  output logic [7:0]  ddrData
);
  typedef enum logic [1:0] {IDLE, MEMWAIT, DONE} state_t;
  state_t state, state_next;
  logic [15:0] rd_buf, mmio_rd;
  logic [7:0] kb_reg;
  logic kb_ready, wr_q, ddr_v, mmio, mmio_go, req;
  assign mmio = MAR[15:9] == 7'h7f;
  assign mmio_go = state == IDLE && memEN && mmio;
  assign mmio_rd = MAR == 16'hfe00 ? {kb_ready, 15'b0}
                 : MAR == 16'hfe02 ? {8'b0, kb_reg}
                 : MAR == 16'hfe04 ? {dispReady, 15'b0} : 16'h0;
  assign req = state == MEMWAIT && !reset;
  assign memReq = req;
  assign memWr = req && wr_q;
  assign memAddr = req ? MAR : 16'h0;
  assign memWData = req ? MDR : 16'h0;
  assign R = state == DONE && !reset;
  assign ddrValid = ddr_v && !reset;
  assign busOut = enaMDR ? MDR : 16'h0;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_comb
    state_next = state == IDLE ? (memEN ? (mmio ? DONE : MEMWAIT) : IDLE)
               : state == MEMWAIT ? (memAck ? DONE : MEMWAIT)
               : (memEN ? DONE : IDLE);
  always_ff @(posedge clk)
    if (reset) begin
      MAR <= '0;
      MDR <= '0;
      rd_buf <= '0;
      kb_reg <= '0;
      kb_ready <= 1'b0;
      wr_q <= 1'b0;
      ddr_v <= 1'b0;
      ddrData <= '0;
    end else begin
      if (ldMAR && state == IDLE) MAR <= busIn;
      if (ldMDR) MDR <= selMDR ? rd_buf : busIn;
      if (kbValid) kb_reg <= kbData;
      if (kbValid) kb_ready <= 1'b1;
      else if (mmio_go && !memWE && MAR == 16'hfe02) kb_ready <= 1'b0;
      if (state == IDLE && memEN && !mmio) wr_q <= memWE;
      if (state == MEMWAIT && memAck && !wr_q) rd_buf <= memRData;
      else if (mmio_go && !memWE) rd_buf <= mmio_rd;
      ddr_v <= mmio_go && memWE && MAR == 16'hfe06;
      if (mmio_go && memWE && MAR == 16'hfe06) ddrData <= MDR[7:0];
    end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed self-checking bench for lc3_mem_ctrl
module tb_lc3_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] busIn = '0;
  logic ldMAR = 1'b0, ldMDR = 1'b0, selMDR = 1'b0, memWE = 1'b0, memEN = 1'b0, enaMDR = 1'b0;
  logic [15:0] MAR, MDR, busOut, memAddr, memWData;
  logic [15:0] memRData = '0;
  logic R, memReq, memWr, memAck = 1'b0;
  logic kbValid = 1'b0, dispReady = 1'b0, ddrValid;
  logic [7:0] kbData = '0, ddrData;
  int total = 0, bad = 0;
  lc3_mem_ctrl dut (
    .clk(clk), .reset(reset), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR),
    .memWE(memWE), .memEN(memEN), .enaMDR(enaMDR), .MAR(MAR), .MDR(MDR), .busOut(busOut),
    .R(R), .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck), .kbValid(kbValid), .kbData(kbData),
    .dispReady(dispReady), .ddrValid(ddrValid), .ddrData(ddrData)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_mar(input logic [15:0] v);
    busIn = v;
    ldMAR = 1'b1;
    tick();
    ldMAR = 1'b0;
  endtask
  task automatic load_mdr(input logic [15:0] v);
    busIn = v;
    selMDR = 1'b0;
    ldMDR = 1'b1;
    tick();
    ldMDR = 1'b0;
  endtask
  task automatic mmio_read(input logic [15:0] a, output logic [15:0] d, output logic req_seen, output logic r_seen);
    load_mar(a);
    memWE = 1'b0;
    memEN = 1'b1;
    req_seen = memReq;
    tick();
    req_seen = req_seen | memReq;
    r_seen = R;
    memEN = 1'b0;
    tick();
    req_seen = req_seen | memReq;
    selMDR = 1'b1;
    ldMDR = 1'b1;
    tick();
    ldMDR = 1'b0;
    selMDR = 1'b0;
    d = MDR;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total++; if (MAR !== 16'h0) begin bad++; $display("FAIL reset_mar got=%h exp=0000", MAR); end
    total++; if (MDR !== 16'h0) begin bad++; $display("FAIL reset_mdr got=%h exp=0000", MDR); end
    total++; if ({R, memReq, memWr, ddrValid} !== 4'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=0000", {R, memReq, memWr, ddrValid}); end
    total++; if ({memAddr, memWData} !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h exp=00000000", {memAddr, memWData}); end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_mem_read;
    int hi;
    load_mar(16'h3000);
    memWE = 1'b0;
    memEN = 1'b1;
    memRData = 16'h1234;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (memReq) hi++;
      total++; if (R !== 1'b0) begin bad++; $display("FAIL rd_r_early cyc=%0d got=%b exp=0", i, R); end
    end
    total++; if (memAddr !== 16'h3000 || memWr !== 1'b0) begin bad++; $display("FAIL rd_addr got=%h/%b exp=3000/0", memAddr, memWr); end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    total++; if (hi !== 3) begin bad++; $display("FAIL rd_req_cycles got=%0d exp=3", hi); end
    total++; if ({R, memReq} !== 2'b10) begin bad++; $display("FAIL rd_done got=%b exp=10", {R, memReq}); end
    memEN = 1'b0;
    tick();
    total++; if (R !== 1'b0) begin bad++; $display("FAIL rd_idle_r got=%b exp=0", R); end
    selMDR = 1'b1;
    ldMDR = 1'b1;
    tick();
    ldMDR = 1'b0;
    enaMDR = 1'b1;
    #1;
    total++; if (MDR !== 16'h1234) begin bad++; $display("FAIL rd_mdr got=%h exp=1234", MDR); end
    total++; if (busOut !== 16'h1234) begin bad++; $display("FAIL rd_busout got=%h exp=1234", busOut); end
    enaMDR = 1'b0;
    #1;
    total++; if (busOut !== 16'h0) begin bad++; $display("FAIL busout_off got=%h exp=0000", busOut); end
  endtask
  task automatic test_mem_write;
    load_mar(16'h4000);
    load_mdr(16'hbeef);
    memWE = 1'b1;
    memEN = 1'b1;
    tick();
    total++; if ({memReq, memWr} !== 2'b11) begin bad++; $display("FAIL wr_strobes got=%b exp=11", {memReq, memWr}); end
    total++; if (memWData !== 16'hbeef || memAddr !== 16'h4000) begin bad++; $display("FAIL wr_bus got=%h/%h exp=beef/4000", memWData, memAddr); end
    memAck = 1'b1;
    memRData = 16'h9999;
    tick();
    memAck = 1'b0;
    total++; if ({R, memReq} !== 2'b10) begin bad++; $display("FAIL wr_done got=%b exp=10", {R, memReq}); end
    memEN = 1'b0;
    memWE = 1'b0;
    tick();
    selMDR = 1'b1;
    ldMDR = 1'b1;
    tick();
    ldMDR = 1'b0;
    total++; if (MDR !== 16'h1234) begin bad++; $display("FAIL wr_no_capture got=%h exp=1234", MDR); end
  endtask
  task automatic test_keyboard;
    logic [15:0] d;
    logic rq, rr;
    kbData = 8'h41;
    kbValid = 1'b1;
    tick();
    kbValid = 1'b0;
    kbData = 8'h00;
    mmio_read(16'hfe00, d, rq, rr);
    total++; if (d !== 16'h8000 || rq !== 1'b0 || rr !== 1'b1) begin bad++; $display("FAIL kbsr_set got=%h req=%b r=%b exp=8000 0 1", d, rq, rr); end
    mmio_read(16'hfe02, d, rq, rr);
    total++; if (d !== 16'h0041 || rq !== 1'b0) begin bad++; $display("FAIL kbdr got=%h req=%b exp=0041 0", d, rq); end
    mmio_read(16'hfe00, d, rq, rr);
    total++; if (d !== 16'h0000 || rq !== 1'b0) begin bad++; $display("FAIL kbsr_clr got=%h req=%b exp=0000 0", d, rq); end
    kbData = 8'h42;
    kbValid = 1'b1;
    load_mar(16'hfe02);
    memEN = 1'b1;
    kbData = 8'h43;
    tick();
    kbValid = 1'b0;
    memEN = 1'b0;
    tick();
    mmio_read(16'hfe00, d, rq, rr);
    total++; if (d !== 16'h8000) begin bad++; $display("FAIL kb_race_sr got=%h exp=8000", d); end
    mmio_read(16'hfe02, d, rq, rr);
    total++; if (d !== 16'h0043) begin bad++; $display("FAIL kb_race_dr got=%h exp=0043", d); end
    dispReady = 1'b1;
    mmio_read(16'hfe04, d, rq, rr);
    total++; if (d !== 16'h8000) begin bad++; $display("FAIL dsr got=%h exp=8000", d); end
    dispReady = 1'b0;
    mmio_read(16'hfe04, d, rq, rr);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL dsr_lo got=%h exp=0000", d); end
    mmio_read(16'hfe10, d, rq, rr);
    total++; if (d !== 16'h0000 || rq !== 1'b0) begin bad++; $display("FAIL mmio_other got=%h req=%b exp=0000 0", d, rq); end
  endtask
  task automatic test_display;
    load_mar(16'hfe06);
    load_mdr(16'h0058);
    memWE = 1'b1;
    memEN = 1'b1;
    #1;
    total++; if (ddrValid !== 1'b0) begin bad++; $display("FAIL ddr_pre got=%b exp=0", ddrValid); end
    tick();
    total++; if ({ddrValid, ddrData} !== {1'b1, 8'h58}) begin bad++; $display("FAIL ddr_pulse got=%b/%h exp=1/58", ddrValid, ddrData); end
    total++; if ({R, memReq} !== 2'b10) begin bad++; $display("FAIL ddr_done got=%b exp=10", {R, memReq}); end
    tick();
    total++; if (ddrValid !== 1'b0) begin bad++; $display("FAIL ddr_one_cycle got=%b exp=0", ddrValid); end
    memEN = 1'b0;
    tick();
    load_mar(16'hfe08);
    memEN = 1'b1;
    tick();
    total++; if ({ddrValid, memReq} !== 2'b00) begin bad++; $display("FAIL mmio_wr_other got=%b exp=00", {ddrValid, memReq}); end
    memEN = 1'b0;
    memWE = 1'b0;
    tick();
  endtask
  task automatic test_abort;
    load_mar(16'h2000);
    memEN = 1'b1;
    tick();
    memEN = 1'b0;
    tick();
    total++; if (memReq !== 1'b1) begin bad++; $display("FAIL abort_hold got=%b exp=1", memReq); end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    total++; if ({R, memReq} !== 2'b10) begin bad++; $display("FAIL abort_done got=%b exp=10", {R, memReq}); end
    tick();
    total++; if (R !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", R); end
  endtask
  task automatic test_reset_memwait;
    load_mar(16'h3000);
    memEN = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++; if ({memReq, memAddr} !== 17'h0) begin bad++; $display("FAIL rst_mw_now got=%b/%h exp=0/0000", memReq, memAddr); end
    tick();
    reset = 1'b0;
    memEN = 1'b0;
    #1;
    total++; if ({memReq, R, MAR} !== 18'h0) begin bad++; $display("FAIL rst_mw_after got=%b/%b/%h exp=0/0/0000", memReq, R, MAR); end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    total++; if ({memReq, R} !== 2'b00) begin bad++; $display("FAIL rst_late_ack got=%b exp=00", {memReq, R}); end
    tick();
    total++; if (R !== 1'b0) begin bad++; $display("FAIL rst_late_ack2 got=%b exp=0", R); end
  endtask
  task automatic test_ldmar_memwait;
    load_mar(16'h6000);
    memEN = 1'b1;
    tick();
    busIn = 16'h5555;
    ldMAR = 1'b1;
    tick();
    ldMAR = 1'b0;
    total++; if (MAR !== 16'h6000 || memAddr !== 16'h6000 || memReq !== 1'b1) begin bad++; $display("FAIL ldmar_mw got=%h/%h/%b exp=6000/6000/1", MAR, memAddr, memReq); end
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    memEN = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_keyboard();
    test_display();
    test_abort();
    test_reset_memwait();
    test_ldmar_memwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
